// File: rtl/lsu_pkg.sv
// Shared types for the LSU request queue: size encodings, queue-entry layout
// and exception bit positions.
package lsu_pkg;

  localparam int LSU_ADDR_MAX = 64;
  localparam int LSU_DATA_MAX = 64;
  localparam int LSU_TAG_MAX  = 16;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_e;

  // Bit positions inside the exception vector, matching excp_num ordering.
  localparam int EXC_ALE  = 0;
  localparam int EXC_ADEM = 1;
  localparam int EXC_W    = 2;

  // Fields are sized for the widest configuration; narrower builds use the LSBs.
  typedef struct packed {
    logic [LSU_ADDR_MAX-1:0]   addr;
    logic                      op;
    logic [1:0]                size;
    logic [LSU_DATA_MAX/8-1:0] wstrb;
    logic [LSU_DATA_MAX-1:0]   wdata;
    logic [LSU_TAG_MAX-1:0]    tag;
  } lsu_entry_t;

endpackage

// File: rtl/lsu_store_align.sv
// Combinational store lane formatter: byte strobes, replicated store data and
// the misalignment check for one request.
module lsu_store_align
  import lsu_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int OFF_W  = $clog2(NB)
) (
  input  logic [1:0]        size,
  input  logic [OFF_W-1:0]  off,
  input  logic [DATA_W-1:0] wdata,
  input  logic              store,
  output logic [NB-1:0]     wstrb,
  output logic [DATA_W-1:0] wdata_aligned,
  output logic              ale
);

  always_comb begin
    wstrb         = '0;
    wdata_aligned = '0;
    ale           = 1'b0;
    case (size)
      SZ_B: begin
        wstrb         = NB'(1) << off;
        wdata_aligned = {NB{wdata[7:0]}};
      end
      SZ_H: begin
        wstrb         = NB'(2'b11) << off;
        wdata_aligned = {(NB/2){wdata[15:0]}};
        ale           = off[0];
      end
      SZ_W: begin
        wstrb         = NB'(4'hF) << off;
        wdata_aligned = {(NB/4){wdata[31:0]}};
        ale           = off[1:0] != 2'b00;
      end
      default: begin
        // A 32-bit datapath has no double lane, so every double access faults.
        wstrb         = '1;
        wdata_aligned = wdata;
        ale           = (DATA_W == 32) ? 1'b1 : (off != '0);
      end
    endcase
    if (!store) begin
      wstrb         = '0;
      wdata_aligned = '0;
    end
  end

endmodule

// File: rtl/lsu_req_queue.sv
// DEPTH-entry request FIFO between execute and the data-cache request port.
// Optional macro LSU_ADEM_CHECK_EN enables the user-mode high-address check.
module lsu_req_queue
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_store,
  input  logic [1:0]               in_size,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_wdata,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic [1:0]               in_plv,
  output logic                     data_valid,
  output logic                     data_op,
  output logic [2:0]               data_size,
  output logic [ADDR_W-1:0]        data_addr,
  output logic [DATA_W/8-1:0]      data_wstrb,
  output logic [DATA_W-1:0]        data_wdata,
  output logic [TAG_W-1:0]         data_tag,
  input  logic                     data_addr_ok,
  output logic                     excp_valid,
  output logic                     excp_ale,
  output logic                     excp_adem,
  output logic [ADDR_W-1:0]        excp_badv,
  output logic [TAG_W-1:0]         excp_tag,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  lsu_entry_t           mem_q [DEPTH];
  lsu_entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d, count_q, count_d;
  logic                 excp_valid_q, excp_valid_d;
  logic [EXC_W-1:0]     excp_q, excp_d;
  logic [ADDR_W-1:0]    badv_q, badv_d;
  logic [TAG_W-1:0]     etag_q, etag_d;

  logic                 full, empty, accept, push, pop, ale, adem, fault;
  logic [NB-1:0]        al_strb;
  logic [DATA_W-1:0]    al_wdata;
  lsu_entry_t           enq_e, head_e;
  logic                 unused_head;

  assign full       = count_q == PTR_W'(DEPTH);
  assign empty      = count_q == '0;
  assign in_ready   = resetn && !full && !flush;
  assign data_valid = resetn && !empty && !flush;
  assign accept     = in_valid && in_ready;
  assign fault      = ale || adem;
  assign push       = accept && !fault;
  assign pop        = data_valid && data_addr_ok;

  lsu_store_align #(.DATA_W(DATA_W)) u_align (
    .size          (in_size),
    .off           (in_addr[OFF_W-1:0]),
    .wdata         (in_wdata),
    .store         (in_store),
    .wstrb         (al_strb),
    .wdata_aligned (al_wdata),
    .ale           (ale)
  );

`ifdef LSU_ADEM_CHECK_EN
  assign adem = in_addr[ADDR_W-1] && (in_plv == 2'd3);
`else
  logic unused_plv;
  assign adem       = 1'b0;
  assign unused_plv = ^in_plv;
`endif

  always_comb begin
    enq_e                    = '0;
    enq_e.addr[ADDR_W-1:0]   = in_addr;
    enq_e.op                 = in_store;
    enq_e.size               = in_size;
    enq_e.wstrb[NB-1:0]      = al_strb;
    enq_e.wdata[DATA_W-1:0]  = al_wdata;
    enq_e.tag[TAG_W-1:0]     = in_tag;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (flush) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q[IDX_W-1:0]] = enq_e;
        tail_d = tail_q + PTR_W'(1);
      end
      if (pop) head_d = head_q + PTR_W'(1);
      count_d = count_q + PTR_W'(push) - PTR_W'(pop);
    end
  end

  // Faulting requests complete the handshake but only report, never enqueue.
  always_comb begin
    excp_valid_d = accept && fault;
    excp_d       = '0;
    badv_d       = badv_q;
    etag_d       = etag_q;
    if (excp_valid_d) begin
      excp_d[EXC_ALE]  = ale;
      excp_d[EXC_ADEM] = adem;
      badv_d           = in_addr;
      etag_d           = in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      excp_valid_q <= 1'b0;
      excp_q       <= '0;
      badv_q       <= '0;
      etag_q       <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      excp_valid_q <= excp_valid_d;
      excp_q       <= excp_d;
      badv_q       <= badv_d;
      etag_q       <= etag_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_e      = mem_q[head_q[IDX_W-1:0]];
  assign unused_head = ^head_e;

  assign data_op    = head_e.op;
  assign data_size  = {1'b0, head_e.size};
  assign data_addr  = head_e.addr[ADDR_W-1:0];
  assign data_wstrb = head_e.wstrb[NB-1:0];
  assign data_wdata = head_e.wdata[DATA_W-1:0];
  assign data_tag   = head_e.tag[TAG_W-1:0];

  assign excp_valid = excp_valid_q;
  assign excp_ale   = excp_q[EXC_ALE];
  assign excp_adem  = excp_q[EXC_ADEM];
  assign excp_badv  = badv_q;
  assign excp_tag   = etag_q;
  assign q_count    = count_q;

endmodule
